// File: rtl/compare_press.sv
// compare_press: run-time selectable unsigned comparator with a registered match,
// rising-edge press pulses rate-limited by a cooldown window, and a saturating press count.
module compare_press #(
    parameter int WIDTH     = 10,
    parameter int COOLDOWN  = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 match,
    output logic                 press,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] press_count
);
    localparam int CW = COOLDOWN > 1 ? $clog2(COOLDOWN) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(COOLDOWN - 1);

    typedef enum logic {IDLE, COOL} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          rel, cmp, rise, accept, fire;

    always_comb begin
        rel    = mode == 2'b00 ? A > B :
                 mode == 2'b01 ? A >= B :
                 mode == 2'b10 ? A < B : A == B;
        cmp    = en & rel;
        rise   = cmp & ~match;
        accept = state == IDLE || cnt == '0;
        fire   = rise & accept;
    end

    // A rise arriving at cnt==0 restarts the window without passing through IDLE.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == IDLE) begin
            if (rise) begin
                state_n = COOL;
                cnt_n   = RELOAD;
            end
        end else if (cnt != '0)
            cnt_n = cnt - CW'(1);
        else if (rise)
            cnt_n = RELOAD;
        else
            state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            match       <= 1'b0;
            press       <= 1'b0;
            press_count <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            match       <= cmp;
            press       <= fire;
            press_count <= fire && press_count != '1 ? press_count + CNT_WIDTH'(1) : press_count;
        end
    end

    assign busy = state == COOL;
endmodule

// File: tb/tb_compare_press.sv
// tb_compare_press: directed checks of compare_press; a second instance with a
// 2-bit press counter shares the stimulus to exercise count saturation.
module tb_compare_press;
    logic       clk = 1'b0;
    logic       Reset, en;
    logic [1:0] mode;
    logic [9:0] A, B;
    logic       match, press, busy;
    logic [7:0] press_count;
    logic       match2, press2, busy2;
    logic [1:0] press_count2;

    int n_checks = 0;
    int n_fail   = 0;

    compare_press dut (
        .clk(clk), .Reset(Reset), .en(en), .mode(mode), .A(A), .B(B),
        .match(match), .press(press), .busy(busy), .press_count(press_count)
    );

    compare_press #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .Reset(Reset), .en(en), .mode(mode), .A(A), .B(B),
        .match(match2), .press(press2), .busy(busy2), .press_count(press_count2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [11:0] pat;
        logic        all_busy;
        int          presses;

        Reset = 1'b1; en = 1'b1; mode = 2'b00; A = 10'h200; B = 10'h100;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_match", {31'd0, match}, 0);
            chk("rst_press", {31'd0, press}, 0);
            chk("rst_busy", {31'd0, busy}, 0);
            chk("rst_count", {24'd0, press_count}, 0);
        end

        Reset = 1'b0;
        tick();
        chk("first_match", {31'd0, match}, 1);
        chk("first_press", {31'd0, press}, 1);
        chk("first_count", {24'd0, press_count}, 1);
        chk("first_busy", {31'd0, busy}, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_hold", {31'd0, busy}, 1);
            chk("press_width", {31'd0, press}, 0);
        end
        tick();
        chk("busy_fall", {31'd0, busy}, 0);

        presses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            presses += int'(press);
        end
        chk("held_presses", presses, 0);
        chk("held_match", {31'd0, match}, 1);
        chk("held_count", {24'd0, press_count}, 1);

        A = 10'h155; B = 10'h155;
        mode = 2'b00; tick(); chk("eq_gt", {31'd0, match}, 0);
        mode = 2'b01; tick(); chk("eq_ge", {31'd0, match}, 1);
        mode = 2'b10; tick(); chk("eq_lt", {31'd0, match}, 0);
        mode = 2'b11; tick(); chk("eq_eq", {31'd0, match}, 1);
        A = 10'h3FF; B = 10'h000; mode = 2'b00; tick();
        chk("max_gt", {31'd0, match}, 1);
        A = 10'h000; B = 10'h3FF; mode = 2'b10; tick();
        chk("min_lt", {31'd0, match}, 1);

        en = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_match", {31'd0, match}, 0);

        // Cooldown drop: alternating A produces a rise every other cycle.
        en = 1'b1; mode = 2'b00; B = 10'h100;
        pat = '0; all_busy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            A = (i % 2 == 0) ? 10'h200 : 10'h000;
            tick();
            pat[i] = press;
            all_busy &= busy;
        end
        chk("cool_pattern", {20'd0, pat}, 32'h111);
        chk("cool_busy", {31'd0, all_busy}, 1);

        en = 1'b0; A = 10'h200; B = 10'h100;
        presses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("gate_match", {31'd0, match}, 0);
            presses += int'(press);
        end
        chk("gate_presses", presses, 0);
        en = 1'b1; tick();
        chk("gate_press", {31'd0, press}, 1);
        chk("gate_match_on", {31'd0, match}, 1);

        Reset = 1'b1; en = 1'b0; tick();
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en = 1'b1; tick();
            chk("sat_press", {31'd0, press2}, 1);
            chk("sat_count2", {30'd0, press_count2}, (i < 3) ? i + 1 : 3);
            chk("sat_count8", {24'd0, press_count}, i + 1);
            en = 1'b0;
            for (int j = 0; j < 5; j++) tick();
        end

        en = 1'b1; tick();
        chk("mid_busy_pre", {31'd0, busy}, 1);
        Reset = 1'b1; tick();
        chk("mid_busy", {31'd0, busy}, 0);
        chk("mid_count", {24'd0, press_count}, 0);
        chk("mid_count2", {30'd0, press_count2}, 0);
        chk("mid_match", {31'd0, match}, 0);
        chk("mid_press", {31'd0, press}, 0);
        Reset = 1'b0; tick();
        chk("rel_press", {31'd0, press}, 1);
        chk("rel_count", {24'd0, press_count}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/compare_press.md
# compare_press

Parametrised comparator and press generator for the computer player. Compares two unsigned WIDTH-bit operands under a run-time selectable relation. Registers the result. Turns each new match into a single-cycle `press` pulse, rate-limited by a cooldown window, and keeps a saturating count of issued presses. It sits between the random-value source and the game controller, in place of the fixed 10-bit "A > B" comparator.

## Interface
- `WIDTH`, default 10: operand width in bits.
- `COOLDOWN`, default 4: minimum spacing between presses, in cycles; legal range ≥1.
- `CNT_WIDTH`, default 8: width of `press_count`.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `Reset`, in, 1: synchronous, active-high reset; dominates all other inputs.
- `en`, in, 1: compare enable; when low, the comparison is forced false.
- `mode`, in, 2: relation select: 00 A>B, 01 A≥B, 10 A<B, 11 A==B.
- `A`, in, WIDTH: operand A, unsigned.
- `B`, in, WIDTH: operand B, unsigned.
- `match`, out, 1: registered comparison result.
- `press`, out, 1: single-cycle press pulse.
- `busy`, out, 1: high while the cooldown window is active.
- `press_count`, out, CNT_WIDTH: number of presses issued, saturating.

## Operation
- `cmp` = `en` & relation(`A`, `B`, `mode`).
  - Unsigned compare at full WIDTH.
  - No sign or width extension.
- `rise` = `cmp` & ~`match`, where `match` is the current register value.
- Registers updated each edge, `Reset` low:
  - `match` <= `cmp`.
  - `press` <= `rise` & `accept`.
- `accept` = (state==IDLE) | (state==COOL & cnt==0).
- FSM states are IDLE and COOL. A down-counter `cnt` is sized to hold COOLDOWN-1.
  - IDLE: on `rise` → COOL, cnt <= COOLDOWN-1. Otherwise stay in IDLE.
  - COOL, cnt>0: cnt <= cnt-1. Any `rise` is dropped; it is not queued.
  - COOL, cnt==0:
    - On `rise`: accept the press, stay in COOL, cnt <= COOLDOWN-1.
    - Otherwise: → IDLE.
- `busy` = (state==COOL). It is high in the same cycle as `press` and stays high exactly COOLDOWN cycles per press.
- `press_count` increments by 1 on each accepted press and holds at 2^CNT_WIDTH-1.
- A level match held high produces only one press. A new press requires `match` to fall first, via an operand change, a `mode` change, or `en` low.
- A `mode` or operand change that makes `cmp` go from 0 to 1 counts as a rise.
- `en` low forces `match` to 0 on the next edge, which re-arms edge detection.
- `Reset`:
  - `match`=0, `press`=0, `busy`=0, `press_count`=0, state=IDLE, cnt=0.
  - Mid-cooldown reset aborts the window. Outputs read zero in the cycle after the reset edge.
- If `cmp` is already true when `Reset` deasserts, the first edge with `Reset` low yields a rise and a press.

## Timing
- Latency from inputs to `match`: 1 cycle (edge after inputs settle).
- Latency from inputs to `press`: 1 cycle. `press` and `match` go high in the same cycle on an accepted rise.
- `press` width: exactly 1 cycle.
- Minimum spacing between `press` pulses: COOLDOWN cycles, start to start.
- `press_count` updates in the same cycle that `press` is high.
- `busy` falls COOLDOWN cycles after `press` rises, unless a new press is accepted at cnt==0. In that case `busy` stays high continuously.
- No combinational path from inputs to any output.

## Test plan
- **Reset and first press.** Reset high 4 cycles with A=10'h200, B=10'h100, mode=00, en=1.
  - During reset: all outputs 0.
  - First cycle after release: `match`=1, `press`=1, `press_count`=1.
  - `busy`=1 for 4 cycles, then 0.
- **Held match.** Hold A>B for 20 cycles → exactly one `press`. `match` stays 1 and `press_count` stays 1.
- **Mode sweep.**
  - A=B=10'h155: mode 00 → `match` 0; 01 → 1; 10 → 0; 11 → 1.
  - A=10'h3FF, B=0, mode 00 → 1 (unsigned check).
  - A=0, B=10'h3FF, mode 10 → 1.
- **Cooldown drop.** COOLDOWN=4, B=10'h100, A alternating 10'h200 and 10'h000 every cycle.
  - `press` pulses exactly 4 cycles apart.
  - Intervening rises are dropped.
  - `busy` stays continuously high.
- **Enable gating.** A>B with en=0 for 5 cycles → `match`=0 and no `press`. Set en=1 → `press`=1 on the next cycle.
- **Saturation and reset mid-cooldown.**
  - CNT_WIDTH=2, 5 spaced presses → `press_count` holds at 3.
  - Reset asserted while `busy`=1 → next cycle `busy`=0 and `press_count`=0.
